// File: rtl/phase_pkg.sv
// Shared types and constants for the FFT post-processing blocks (peak search, phase).
package phase_pkg;

    localparam int FFT_DEPTH_DEF = 11;
    localparam int FFT_WIDTH_DEF = 25;
    localparam int PEAK_LATENCY  = 4;

    typedef logic signed [FFT_WIDTH_DEF-1:0] fft_sample_t;
    typedef logic        [2*FFT_WIDTH_DEF-1:0] fft_mag_t;

    typedef enum logic {
        IDLE,
        FRAME
    } peak_state_t;

endpackage

// File: rtl/fft_peak_detect_mag_sq.sv
// mag_sq: two registered stages computing Re^2+Im^2, carrying the sample's
// Re/Im, bin index and frame flags alongside so they stay aligned with the magnitude.
module mag_sq #(
    parameter int FFT_DEPTH = 11,
    parameter int FFT_WIDTH = 25
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [FFT_WIDTH-1:0]   i_re,
    input  logic signed [FFT_WIDTH-1:0]   i_im,
    input  logic [FFT_DEPTH-1:0]          i_bin,
    input  logic                          i_sop,
    input  logic                          i_eop,
    input  logic                          i_valid,
    input  logic                          i_err,
    output logic signed [FFT_WIDTH-1:0]   o_re,
    output logic signed [FFT_WIDTH-1:0]   o_im,
    output logic [FFT_DEPTH-1:0]          o_bin,
    output logic [2*FFT_WIDTH-1:0]        o_mag,
    output logic                          o_sop,
    output logic                          o_eop,
    output logic                          o_valid,
    output logic                          o_err
);

    // A square is never negative and at most 2^(2W-2), so 2W-1 bits hold it exactly.
    logic signed [2*FFT_WIDTH-2:0] w_reExt;
    logic signed [2*FFT_WIDTH-2:0] w_imExt;
    logic        [2*FFT_WIDTH-2:0] w_reSq;
    logic        [2*FFT_WIDTH-2:0] w_imSq;

    assign w_reExt = {{(FFT_WIDTH-1){i_re[FFT_WIDTH-1]}}, i_re};
    assign w_imExt = {{(FFT_WIDTH-1){i_im[FFT_WIDTH-1]}}, i_im};
    assign w_reSq  = w_reExt * w_reExt;
    assign w_imSq  = w_imExt * w_imExt;

    logic        [2*FFT_WIDTH-2:0] r_reSq, r_imSq;
    logic signed [FFT_WIDTH-1:0]   r_aRe, r_aIm, r_bRe, r_bIm;
    logic        [FFT_DEPTH-1:0]   r_aBin, r_bBin;
    logic        [3:0]             r_aFlags, r_bFlags;
    logic        [2*FFT_WIDTH-1:0] r_mag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reSq   <= '0;
            r_imSq   <= '0;
            r_aRe    <= '0;
            r_aIm    <= '0;
            r_aBin   <= '0;
            r_aFlags <= '0;
            r_mag    <= '0;
            r_bRe    <= '0;
            r_bIm    <= '0;
            r_bBin   <= '0;
            r_bFlags <= '0;
        end else begin
            r_reSq   <= w_reSq;
            r_imSq   <= w_imSq;
            r_aRe    <= i_re;
            r_aIm    <= i_im;
            r_aBin   <= i_bin;
            r_aFlags <= {i_valid, i_sop, i_eop, i_err};
            r_mag    <= {1'b0, r_reSq} + {1'b0, r_imSq};
            r_bRe    <= r_aRe;
            r_bIm    <= r_aIm;
            r_bBin   <= r_aBin;
            r_bFlags <= r_aFlags;
        end
    end

    assign o_re    = r_bRe;
    assign o_im    = r_bIm;
    assign o_bin   = r_bBin;
    assign o_mag   = r_mag;
    assign o_valid = r_bFlags[3];
    assign o_sop   = r_bFlags[2];
    assign o_eop   = r_bFlags[1];
    assign o_err   = r_bFlags[0];

endmodule

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: scans one FFT output frame for the strongest bin in
// [BIN_MIN, BIN_MAX] and reports its index, Re/Im and |X|^2, or flags a malformed frame.
module fft_peak_detect
    import phase_pkg::*;
#(
    parameter int FFT_DEPTH = FFT_DEPTH_DEF,
    parameter int FFT_WIDTH = FFT_WIDTH_DEF,
    parameter int BIN_MIN   = 1,
    parameter int BIN_MAX   = 1023
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sink_sop,
    input  logic                          sink_eop,
    input  logic                          sink_valid,
    input  logic signed [FFT_WIDTH-1:0]   sink_re,
    input  logic signed [FFT_WIDTH-1:0]   sink_im,
    output logic                          source_valid,
    output logic [FFT_DEPTH-1:0]          source_bin,
    output logic signed [FFT_WIDTH-1:0]   source_re,
    output logic signed [FFT_WIDTH-1:0]   source_im,
    output logic [2*FFT_WIDTH-1:0]        source_mag,
    output logic                          error
);

    localparam logic [FFT_DEPTH-1:0] BIN_LO   = FFT_DEPTH'(BIN_MIN);
    localparam logic [FFT_DEPTH-1:0] BIN_HI   = FFT_DEPTH'(BIN_MAX);
    localparam logic [FFT_DEPTH-1:0] LAST_BIN = '1;

    peak_state_t                 r_state, w_nextState;
    logic [FFT_DEPTH-1:0]        r_binCnt;
    logic [FFT_DEPTH-1:0]        w_bin;
    logic                        w_accept;
    logic                        w_err;

    assign w_bin    = sink_sop ? '0 : r_binCnt + FFT_DEPTH'(1);
    assign w_accept = sink_valid && (sink_sop || (r_state == FRAME));
    assign w_err    = w_accept && ((sink_sop && ((r_state == FRAME) || sink_eop)) ||
                                   (sink_eop && (w_bin != LAST_BIN)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // A sop always (re)opens a frame unless it also closes it; any accepted eop closes it.
    always_comb begin
        w_nextState = r_state;
        if (sink_valid && sink_sop && !sink_eop)
            w_nextState = FRAME;
        else if (w_accept && sink_eop)
            w_nextState = IDLE;
    end

    logic signed [FFT_WIDTH-1:0] r_s1Re, r_s1Im;
    logic [FFT_DEPTH-1:0]        r_s1Bin;
    logic                        r_s1Valid, r_s1Sop, r_s1Eop, r_s1Err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_binCnt  <= '0;
            r_s1Re    <= '0;
            r_s1Im    <= '0;
            r_s1Bin   <= '0;
            r_s1Valid <= 1'b0;
            r_s1Sop   <= 1'b0;
            r_s1Eop   <= 1'b0;
            r_s1Err   <= 1'b0;
        end else begin
            if (w_accept) r_binCnt <= w_bin;
            r_s1Re    <= sink_re;
            r_s1Im    <= sink_im;
            r_s1Bin   <= w_bin;
            r_s1Valid <= w_accept;
            r_s1Sop   <= sink_valid && sink_sop;
            r_s1Eop   <= w_accept && sink_eop;
            r_s1Err   <= w_err;
        end
    end

    logic signed [FFT_WIDTH-1:0] w_mRe, w_mIm;
    logic [FFT_DEPTH-1:0]        w_mBin;
    logic [2*FFT_WIDTH-1:0]      w_mMag;
    logic                        w_mSop, w_mEop, w_mValid, w_mErr;

    mag_sq #(
        .FFT_DEPTH (FFT_DEPTH),
        .FFT_WIDTH (FFT_WIDTH)
    ) u_magSq (
        .clk     (clk),
        .reset   (reset),
        .i_re    (r_s1Re),
        .i_im    (r_s1Im),
        .i_bin   (r_s1Bin),
        .i_sop   (r_s1Sop),
        .i_eop   (r_s1Eop),
        .i_valid (r_s1Valid),
        .i_err   (r_s1Err),
        .o_re    (w_mRe),
        .o_im    (w_mIm),
        .o_bin   (w_mBin),
        .o_mag   (w_mMag),
        .o_sop   (w_mSop),
        .o_eop   (w_mEop),
        .o_valid (w_mValid),
        .o_err   (w_mErr)
    );

    logic [2*FFT_WIDTH-1:0]      r_maxMag, w_baseMag;
    logic [FFT_DEPTH-1:0]        r_maxBin, w_baseBin;
    logic signed [FFT_WIDTH-1:0] r_maxRe, r_maxIm, w_baseRe, w_baseIm;
    logic                        w_take;
    logic                        r_doneGood, r_doneErr;

    // The sop sample compares against a cleared max, so each frame starts fresh
    // and an all-zero frame leaves the default bin BIN_MIN with magnitude 0.
    always_comb begin
        w_baseMag = r_maxMag;
        w_baseBin = r_maxBin;
        w_baseRe  = r_maxRe;
        w_baseIm  = r_maxIm;
        if (w_mSop) begin
            w_baseMag = '0;
            w_baseBin = BIN_LO;
            w_baseRe  = '0;
            w_baseIm  = '0;
        end
        w_take = w_mValid && (w_mBin >= BIN_LO) && (w_mBin <= BIN_HI) && (w_mMag > w_baseMag);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_maxMag     <= '0;
            r_maxBin     <= '0;
            r_maxRe      <= '0;
            r_maxIm      <= '0;
            r_doneGood   <= 1'b0;
            r_doneErr    <= 1'b0;
            source_valid <= 1'b0;
            source_bin   <= '0;
            source_re    <= '0;
            source_im    <= '0;
            source_mag   <= '0;
            error        <= 1'b0;
        end else begin
            if (w_mValid) begin
                r_maxMag <= w_take ? w_mMag : w_baseMag;
                r_maxBin <= w_take ? w_mBin : w_baseBin;
                r_maxRe  <= w_take ? w_mRe  : w_baseRe;
                r_maxIm  <= w_take ? w_mIm  : w_baseIm;
            end
            r_doneGood   <= w_mValid && w_mEop && !w_mErr;
            r_doneErr    <= w_mValid && w_mErr;
            source_valid <= r_doneGood;
            error        <= r_doneErr;
            if (r_doneGood) begin
                source_bin <= r_maxBin;
                source_re  <= r_maxRe;
                source_im  <= r_maxIm;
                source_mag <= r_maxMag;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: a frame-level reference model queues
// the expected result or error per frame; a monitor checks every output pulse.
`timescale 1ns/1ps
module tb_fft_peak_detect;
    import phase_pkg::*;

    localparam int D       = 11;
    localparam int W       = 25;
    localparam int N       = 2048;
    localparam int BIN_MIN = 1;
    localparam int BIN_MAX = 1023;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  sink_sop, sink_eop, sink_valid;
    logic signed [W-1:0]   sink_re, sink_im;
    logic                  source_valid, error;
    logic [D-1:0]          source_bin;
    logic signed [W-1:0]   source_re, source_im;
    logic [2*W-1:0]        source_mag;

    always #5 clk = ~clk;

    fft_peak_detect #(
        .FFT_DEPTH (D),
        .FFT_WIDTH (W),
        .BIN_MIN   (BIN_MIN),
        .BIN_MAX   (BIN_MAX)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_valid   (sink_valid),
        .sink_re      (sink_re),
        .sink_im      (sink_im),
        .source_valid (source_valid),
        .source_bin   (source_bin),
        .source_re    (source_re),
        .source_im    (source_im),
        .source_mag   (source_mag),
        .error        (error)
    );

    typedef struct {
        bit     isErr;
        int     bin;
        longint re;
        longint im;
        longint mag;
        int     cyc;
    } expect_t;

    expect_t expQ[$];
    expect_t lastGood;
    expect_t monItem;
    int      cyc = 0;
    int      checks = 0;
    int      passes = 0;
    longint  frameRe[N];
    longint  frameIm[N];
    longint  capRe[$];
    longint  capIm[$];
    bit      inFrame = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint want);
        checks++;
        if (act == want) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    endtask

    // Reference: the strongest bin in range, first one wins on equal magnitude.
    function automatic expect_t modelPeak();
        expect_t r;
        longint  m;
        r.isErr = 1'b0; r.bin = BIN_MIN; r.re = 0; r.im = 0; r.mag = 0; r.cyc = 0;
        for (int b = BIN_MIN; b <= BIN_MAX; b++) begin
            m = capRe[b] * capRe[b] + capIm[b] * capIm[b];
            if (m > r.mag) begin
                r.mag = m; r.bin = b; r.re = capRe[b]; r.im = capIm[b];
            end
        end
        return r;
    endfunction

    task automatic pushExpect(input expect_t item);
        item.cyc = cyc + 1 + PEAK_LATENCY;
        expQ.push_back(item);
    endtask

    task automatic pushErr();
        expect_t item;
        item.isErr = 1'b1; item.bin = 0; item.re = 0; item.im = 0; item.mag = 0; item.cyc = 0;
        pushExpect(item);
    endtask

    // Frame-level bookkeeping of what the DUT has been shown.
    task automatic modelAccept(input bit s, input bit e, input longint re, input longint im);
        if (s) begin
            if (inFrame || e) pushErr();
            capRe.delete(); capIm.delete();
            capRe.push_back(re); capIm.push_back(im);
            inFrame = !e;
        end else if (inFrame) begin
            capRe.push_back(re); capIm.push_back(im);
            if (e) begin
                inFrame = 1'b0;
                if (capRe.size() == N) pushExpect(modelPeak());
                else pushErr();
            end
        end
    endtask

    task automatic applyStimulus(input bit v, input bit s, input bit e, input longint re, input longint im);
        @(posedge clk); #1;
        sink_valid = v; sink_sop = s; sink_eop = e;
        sink_re = re[W-1:0]; sink_im = im[W-1:0];
        if (v) modelAccept(s, e, re, im);
    endtask

    task automatic gapCycle();
        logic signed [W-1:0] gr, gi;
        gr = W'($urandom); gi = W'($urandom);
        applyStimulus(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), gr, gi);
    endtask

    task automatic sendFrame(input int len, input bit withEop, input int gapPct, input bit gapBeforeSop);
        for (int b = 0; b < len; b++) begin
            if (gapPct > 0 && (b > 0 || gapBeforeSop))
                while ($urandom_range(99) < gapPct) gapCycle();
            applyStimulus(1'b1, b == 0, withEop && (b == len - 1), frameRe[b], frameIm[b]);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic clearFrame();
        for (int b = 0; b < N; b++) begin frameRe[b] = 0; frameIm[b] = 0; end
    endtask

    task automatic randomFrame();
        logic signed [W-1:0] t;
        for (int b = 0; b < N; b++) begin
            t = W'($urandom); frameRe[b] = t;
            t = W'($urandom); frameIm[b] = t;
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 40 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain: %0d expected pulses still pending, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            checks++;
            $display("[TB] FAIL missedPulse: no output pulse by cycle %0d, expected one (isErr=%0b)",
                     expQ[0].cyc, expQ[0].isErr);
            expQ.delete(0);
        end
        if (source_valid || error) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpectedPulse: valid=%0b error=%0b at cycle %0d, required none",
                         source_valid, error, cyc);
            end else begin
                monItem = expQ.pop_front();
                checkOutput("latency", cyc, monItem.cyc);
                checkOutput("errorFlag", error, monItem.isErr);
                checkOutput("validFlag", source_valid, !monItem.isErr);
                if (!monItem.isErr) lastGood = monItem;
                checkOutput("bin", source_bin, lastGood.bin);
                checkOutput("re", $signed(source_re), lastGood.re);
                checkOutput("im", $signed(source_im), lastGood.im);
                checkOutput("mag", source_mag, lastGood.mag);
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Valid"}, source_valid, 0);
        checkOutput({tag, "Error"}, error, 0);
        checkOutput({tag, "Bin"}, source_bin, 0);
        checkOutput({tag, "Re"}, $signed(source_re), 0);
        checkOutput({tag, "Im"}, $signed(source_im), 0);
        checkOutput({tag, "Mag"}, source_mag, 0);
    endtask

    task automatic resetModel();
        inFrame = 1'b0;
        capRe.delete(); capIm.delete();
        lastGood.isErr = 1'b0; lastGood.bin = 0; lastGood.re = 0;
        lastGood.im = 0; lastGood.mag = 0; lastGood.cyc = 0;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        sink_valid = 0; sink_sop = 0; sink_eop = 0; sink_re = 0; sink_im = 0;
        resetModel();
        reset = 1'b1;
        #1 reset = 1'b0;
        #30;
        checkAllZero("reset");
        @(negedge clk); reset = 1'b1;

        $display("[TB] single tone");
        clearFrame(); frameRe[100] = 1000; frameIm[100] = -500;
        sendFrame(N, 1, 0, 0); waitDrain();

        $display("[TB] DC and out-of-range bins");
        clearFrame(); frameRe[0] = (1 << 24) - 1; frameRe[1500] = 1000000;
        frameRe[200] = 3; frameIm[200] = 4;
        sendFrame(N, 1, 0, 0); waitDrain();

        $display("[TB] tie then all-zero");
        clearFrame(); frameRe[300] = 7; frameIm[300] = 7; frameRe[50] = 7; frameIm[50] = 7;
        sendFrame(N, 1, 0, 0); waitDrain();
        clearFrame(); sendFrame(N, 1, 0, 0); waitDrain();

        $display("[TB] extreme negative values");
        clearFrame(); frameRe[10] = -(1 << 24); frameIm[10] = -(1 << 24);
        sendFrame(N, 1, 0, 0); waitDrain();

        $display("[TB] short frame and mid-frame restart");
        randomFrame(); sendFrame(1000, 1, 0, 0); waitDrain();
        randomFrame(); sendFrame(500, 0, 0, 0);
        randomFrame(); sendFrame(N, 1, 0, 0); waitDrain();

        $display("[TB] idle samples and one-sample frame");
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 1'($urandom_range(1)), 99, 99);
        applyStimulus(1, 1, 1, 5, 5);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 1'($urandom_range(1)), 99, 99);
        applyStimulus(0, 0, 0, 0, 0); waitDrain();

        $display("[TB] back-to-back frames with gaps");
        randomFrame(); frameRe[700] = 0; sendFrame(N, 1, 10, 1);
        randomFrame(); sendFrame(N, 1, 10, 0); waitDrain();

        $display("[TB] reset mid-frame");
        randomFrame(); sendFrame(701, 0, 0, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        resetModel();
        #1 checkAllZero("midReset");
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        repeat (8) @(posedge clk);
        randomFrame(); sendFrame(N, 1, 15, 1); waitDrain();

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
